// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction-fetch side (I) and the
// load/store side (D). A request seen in IDLE is latched into the mem_*
// registers, which stay frozen until mem_resp. The response is routed
// combinationally to the owner, and the FSM returns to IDLE for one cycle.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_read, i_addr                I-side read request (held until i_resp)
//   i_rdata, i_resp               I-side read data / completion pulse
//   d_read, d_write, d_addr,
//   d_wdata, d_wmask              D-side request (held until d_resp)
//   d_rdata, d_resp               D-side read data / completion pulse
//   mem_read, mem_write,
//   mem_address, mem_wdata,
//   mem_wmask                     registered memory port command
//   mem_rdata, mem_resp           memory read data / one-cycle completion
//   grant_d                       registered mux select (1 = D owns port)
//
// Build option:
//   MEM_ARB_RR_EN  defined: ties in IDLE go to the side not granted last.
//                  undefined: D wins every tie.
module mem_port_arbiter #(
   parameter int width = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_read,
   input  logic [width-1:0]     i_addr,
   output logic [width-1:0]     i_rdata,
   output logic                 i_resp,
   input  logic                 d_read,
   input  logic                 d_write,
   input  logic [width-1:0]     d_addr,
   input  logic [width-1:0]     d_wdata,
   input  logic [width/8-1:0]   d_wmask,
   output logic [width-1:0]     d_rdata,
   output logic                 d_resp,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [width-1:0]     mem_address,
   output logic [width-1:0]     mem_wdata,
   output logic [width/8-1:0]   mem_wmask,
   input  logic [width-1:0]     mem_rdata,
   input  logic                 mem_resp,
   output logic                 grant_d
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t state, state_nx;
   logic   d_req;
   logic   cap;     // IDLE->SERVE edge: latch the winning request
   logic   cap_d;   // winner of that capture is D

`ifdef MEM_ARB_RR_EN
   logic   last_d;  // side granted most recently (1 = D)
`endif

   assign d_req   = d_read | d_write;

   // Read data is passed through; it only means something alongside _resp.
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   always_comb begin
      state_nx = state;
      cap      = 1'b0;
      cap_d    = 1'b0;
      i_resp   = 1'b0;
      d_resp   = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && i_read) begin
               cap = 1'b1;
`ifdef MEM_ARB_RR_EN
               cap_d = ~last_d;
`else
               cap_d = 1'b1;
`endif
            end else if (d_req) begin
               cap   = 1'b1;
               cap_d = 1'b1;
            end else if (i_read) begin
               cap = 1'b1;
            end
            if (cap) state_nx = cap_d ? SERVE_D : SERVE_I;
         end
         SERVE_I: begin
            if (mem_resp) begin
               i_resp   = 1'b1;
               state_nx = IDLE;
            end
         end
         SERVE_D: begin
            if (mem_resp) begin
               d_resp   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Port registers. Addresses/data keep their last value in IDLE; only the
   // command strobes drop so the memory sees an idle cycle between jobs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_wmask   <= '0;
         grant_d     <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_d      <= 1'b0;
`endif
      end else if (cap) begin
         // D read+write together is illegal; treat it as a write only.
         mem_read    <= cap_d ? (d_read & ~d_write) : 1'b1;
         mem_write   <= cap_d & d_write;
         mem_address <= cap_d ? d_addr : i_addr;
         mem_wdata   <= cap_d ? d_wdata : '0;
         mem_wmask   <= cap_d ? d_wmask : '0;
         grant_d     <= cap_d;
`ifdef MEM_ARB_RR_EN
         last_d      <= cap_d;
`endif
      end else if (i_resp || d_resp) begin
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences (ties, input change in service, reset in service) and a
// randomized phase checked against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read;
   logic [W-1:0]  i_addr;
   logic [W-1:0]  i_rdata;
   logic          i_resp;
   logic          d_read, d_write;
   logic [W-1:0]  d_addr, d_wdata;
   logic [3:0]    d_wmask;
   logic [W-1:0]  d_rdata;
   logic          d_resp;
   logic          mem_read, mem_write;
   logic [W-1:0]  mem_address, mem_wdata;
   logic [3:0]    mem_wmask;
   logic [W-1:0]  mem_rdata;
   logic          mem_resp;
   logic          grant_d;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.width(W)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp), .grant_d(grant_d)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          ir;
      logic [W-1:0]  ia;
      logic          dr, dw;
      logic [W-1:0]  da, dwd;
      logic [3:0]    dm;
      logic [W-1:0]  rd;
      logic          eg, er, ew;
      logic [W-1:0]  ea, ewd;
      logic [3:0]    em;
   } vec_t;

   vec_t tbl [5];

   task automatic drop_all();
      i_read = 0; d_read = 0; d_write = 0;
   endtask

   // One isolated transaction from IDLE: request, command check, response
   // after lat extra cycles, then the IDLE turnaround cycle.
   task automatic do_txn(input vec_t v, input int lat);
      @(posedge clk); #1;
      i_read = v.ir; i_addr = v.ia;
      d_read = v.dr; d_write = v.dw; d_addr = v.da; d_wdata = v.dwd; d_wmask = v.dm;
      @(posedge clk); #1;
      chk("cmd_read",  mem_read,    v.er);
      chk("cmd_write", mem_write,   v.ew);
      chk("cmd_addr",  mem_address, v.ea);
      if (v.eg) chk("cmd_wdata", mem_wdata, v.ewd);
      chk("cmd_wmask", mem_wmask,   v.em);
      chk("cmd_grant", grant_d,     v.eg);
      chk("early_resp", {i_resp, d_resp}, 2'b00);
      repeat (lat) begin
         @(posedge clk); #1;
         chk("hold_addr", mem_address, v.ea);
         chk("wait_resp", {i_resp, d_resp}, 2'b00);
      end
      @(posedge clk); #1;
      mem_resp = 1; mem_rdata = v.rd;
      #1;
      chk("i_resp", i_resp, !v.eg);
      chk("d_resp", d_resp, v.eg);
      chk(v.eg ? "d_rdata" : "i_rdata", v.eg ? d_rdata : i_rdata, v.rd);
      @(posedge clk); #1;
      mem_resp = 0;
      drop_all();
      chk("idle_cmd",  {mem_read, mem_write}, 2'b00);
      chk("idle_grant", grant_d, v.eg);
      chk("idle_resp", {i_resp, d_resp}, 2'b00);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      rst = 1;
      #3;
      rst = 0;
   endtask

   // Reference model state (transaction level)
   logic          m_busy, m_owner, m_r, m_w, m_grant;
   logic [W-1:0]  m_a, m_wd;
   logic [3:0]    m_m;
   int            m_lat;
`ifdef MEM_ARB_RR_EN
   logic          m_last;
`endif

   initial begin
      logic [2:0]  tie_exp;
      logic        rsp, i_done, d_done, dq, win, own;
      int          r;

`ifdef MEM_ARB_RR_EN
      tie_exp = 3'b101;   // D, I, D
`else
      tie_exp = 3'b111;   // D, D, D
`endif

      //              ir ia           dr dw da           dwd          dm       rd           eg er ew ea           ewd          em
      tbl[0] = '{1'b1, 32'h60,       1'b0, 1'b0, 32'h0,   32'h0,       4'h0, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h60,       32'h0,       4'h0};
      tbl[1] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 32'h0,       1'b1, 1'b0, 1'b1, 32'h100,      32'hDEADBEEF, 4'h3};
      tbl[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h44,  32'h0,       4'hF, 32'h0BADF00D, 1'b1, 1'b1, 1'b0, 32'h44,       32'h0,       4'hF};
      tbl[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h80,  32'hCAFE0001, 4'hC, 32'h0,       1'b1, 1'b0, 1'b1, 32'h80,       32'hCAFE0001, 4'hC};
      tbl[4] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,   32'h0,       4'h0, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,       4'h0};

      rst = 1; mem_resp = 0; mem_rdata = 32'h0;
      i_addr = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
      drop_all();
      #1;
      chk("rst_cmd",   {mem_read, mem_write}, 2'b00);
      chk("rst_addr",  mem_address, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_wmask", mem_wmask, 4'h0);
      chk("rst_grant", grant_d, 1'b0);
      chk("rst_resp",  {i_resp, d_resp}, 2'b00);
      #20 rst = 0;

      // Directed vectors; spurious mem_resp in IDLE must be ignored.
      for (int k = 0; k < 5; k++) do_txn(tbl[k], (k % 3) + 1);
      @(posedge clk); #1;
      mem_resp = 1; #1;
      chk("idle_mem_resp", {i_resp, d_resp}, 2'b00);
      @(posedge clk); #1;
      mem_resp = 0;
      chk("idle_mem_resp_state", {mem_read, mem_write}, 2'b00);

      // Back-to-back ties, both sides keep requesting.
      pulse_reset();
      @(posedge clk); #1;
      i_read = 1; i_addr = 32'h10; d_read = 1; d_addr = 32'h20;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("tie_grant", grant_d, tie_exp[k]);
         chk("tie_addr", mem_address, tie_exp[k] ? 32'h20 : 32'h10);
         @(posedge clk); #1;
         mem_resp = 1; #1;
         chk("tie_resp", {i_resp, d_resp}, tie_exp[k] ? 2'b01 : 2'b10);
         @(posedge clk); #1;
         mem_resp = 0;
         if (k == 2) d_read = 0;
         chk("tie_idle", {mem_read, mem_write}, 2'b00);
      end
      @(posedge clk); #1;
      chk("tie_i_last", grant_d, 1'b0);
      chk("tie_i_read", mem_read, 1'b1);
      @(posedge clk); #1;
      mem_resp = 1; #1;
      chk("tie_i_resp", {i_resp, d_resp}, 2'b10);
      @(posedge clk); #1;
      mem_resp = 0; drop_all();

      // Requester inputs change while I is being served.
      @(posedge clk); #1;
      i_read = 1; i_addr = 32'h60;
      @(posedge clk); #1;
      chk("chg_addr0", mem_address, 32'h60);
      i_addr = 32'h200; d_write = 1; d_addr = 32'h300; d_wdata = 32'h11112222; d_wmask = 4'hF;
      @(posedge clk); #1;
      chk("chg_addr1", mem_address, 32'h60);
      chk("chg_cmd", {mem_read, mem_write}, 2'b10);
      chk("chg_grant", grant_d, 1'b0);
      mem_resp = 1; #1;
      chk("chg_iresp", {i_resp, d_resp}, 2'b10);
      @(posedge clk); #1;
      mem_resp = 0; i_read = 0;
      chk("chg_idle", {mem_read, mem_write}, 2'b00);
      @(posedge clk); #1;
      chk("chg_dcmd", {mem_read, mem_write}, 2'b01);
      chk("chg_daddr", mem_address, 32'h300);
      chk("chg_dgrant", grant_d, 1'b1);
      mem_resp = 1; #1;
      chk("chg_dresp", {i_resp, d_resp}, 2'b01);
      @(posedge clk); #1;
      mem_resp = 0; drop_all();

      // Reset while D is waiting for memory.
      @(posedge clk); #1;
      d_write = 1; d_addr = 32'h400; d_wdata = 32'h55; d_wmask = 4'h1;
      @(posedge clk); #1;
      chk("rs_cmd", {mem_read, mem_write, grant_d}, 3'b011);
      #2;
      mem_resp = 1; rst = 1;
      #1;
      chk("rs_cmd0", {mem_read, mem_write}, 2'b00);
      chk("rs_grant0", grant_d, 1'b0);
      chk("rs_resp0", {i_resp, d_resp}, 2'b00);
      chk("rs_addr0", mem_address, 32'h0);
      #4;
      rst = 0; mem_resp = 0; drop_all();
      do_txn(tbl[0], 1);

      // Randomized phase against the transaction-level model.
      pulse_reset();
      m_busy = 0; m_owner = 0; m_grant = 0; m_lat = 0;
      m_r = 0; m_w = 0; m_a = 0; m_wd = 0; m_m = 0;
`ifdef MEM_ARB_RR_EN
      m_last = 0;
`endif
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         if (m_busy) begin
            chk("rnd_read",  mem_read,    m_r);
            chk("rnd_write", mem_write,   m_w);
            chk("rnd_addr",  mem_address, m_a);
            chk("rnd_wmask", mem_wmask,   m_m);
            if (m_owner) chk("rnd_wdata", mem_wdata, m_wd);
         end else begin
            chk("rnd_idle", {mem_read, mem_write}, 2'b00);
         end
         chk("rnd_grant", grant_d, m_grant);

         if (m_busy) begin
            rsp = (m_lat == 0);
            if (m_lat > 0) m_lat--;
         end else begin
            rsp = ($urandom_range(0, 7) == 0);
         end
         i_done = m_busy && rsp && !m_owner;
         d_done = m_busy && rsp && m_owner;
         mem_resp = rsp; mem_rdata = $urandom;
         #1;
         chk("rnd_iresp", i_resp, i_done);
         chk("rnd_dresp", d_resp, d_done);
         if (i_done) chk("rnd_irdata", i_rdata, mem_rdata);
         if (d_done) chk("rnd_drdata", d_rdata, mem_rdata);

         if (i_done || (!i_read && $urandom_range(0, 3) == 0)) begin
            i_read = i_done ? ($urandom_range(0, 1) == 1) : 1'b1;
            i_addr = $urandom;
         end
         if (d_done || (!d_read && !d_write && $urandom_range(0, 3) == 0)) begin
            r = $urandom_range(0, 15);
            d_read  = (r < 7) || (r == 15);
            d_write = (r >= 7);
            if (d_done && $urandom_range(0, 2) == 0) begin d_read = 0; d_write = 0; end
            d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
         end

         // Next-state of the model at the coming edge.
         if (m_busy) begin
            if (rsp) m_busy = 0;
         end else begin
            dq  = d_read | d_write;
            win = dq | i_read;
`ifdef MEM_ARB_RR_EN
            own = (dq && i_read) ? !m_last : dq;
`else
            own = dq;
`endif
            if (win) begin
               m_busy = 1; m_owner = own; m_grant = own;
`ifdef MEM_ARB_RR_EN
               m_last = own;
`endif
               m_lat = $urandom_range(0, 3);
               if (own) begin
                  m_w = d_write; m_r = d_read && !d_write;
                  m_a = d_addr; m_wd = d_wdata; m_m = d_wmask;
               end else begin
                  m_r = 1; m_w = 0; m_a = i_addr; m_wd = 0; m_m = 0;
               end
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single physical memory port between the instruction-fetch requester (I) and the load/store requester (D) of the datapath. Arbitrates between them, latches the winning request, drives the memory port from registers, and routes the response back. Also exports the grant as the select for the datapath's 2:1 address/data mux.

## Interface
- `width`, 32: data and address width in bits. Byte-mask width is `width/8`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_read`  in  1  I-side read request; held until `i_resp`.
- `i_addr`  in  width  I-side address.
- `i_rdata`  out  width  I-side read data; valid when `i_resp`=1.
- `i_resp`  out  1  I-side completion pulse.
- `d_read`, `d_write`  in  1 each  D-side requests; held until `d_resp`.
- `d_addr`, `d_wdata`  in  width  D-side address and write data.
- `d_wmask`  in  width/8  D-side byte enables.
- `d_rdata`  out  width  D-side read data; valid when `d_resp`=1.
- `d_resp`  out  1  D-side completion pulse.
- `mem_read`, `mem_write`  out  1 each  memory port commands.
- `mem_address`, `mem_wdata`  out  width  memory port address and data.
- `mem_wmask`  out  width/8  memory port byte enables.
- `mem_rdata`  in  width  memory read data.
- `mem_resp`  in  1  memory completion, one cycle.
- `grant_d`  out  1  mux select: 0 = I owns the port, 1 = D owns the port.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D. Reset state: IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one side requesting: go to that side's SERVE state. D requests if `d_read|d_write`.
- IDLE, both sides requesting: the tie rule applies (see Configuration).
- On the IDLE→SERVE edge: capture address, wdata, wmask and command into output registers.
  - I-side captures: wmask=0, command=read.
  - If `d_read` and `d_write` are both 1, that is a protocol error. The arbiter issues a write only.
- SERVE_x: hold `mem_*` outputs stable from the registers. Changes on requester inputs are ignored.
- SERVE_x with `mem_resp`=1:
  - `x_resp`=1 in the same cycle, combinationally.
  - `x_rdata` = `mem_rdata`.
  - Next state: IDLE.
- The non-granted `_resp` is always 0. Both `i_rdata` and `d_rdata` pass `mem_rdata` through unconditionally; they are only meaningful with their `_resp`.
- A requester deasserting mid-transaction does not abort it. The memory operation completes and the `_resp` pulse is still produced.
- `grant_d` is registered:
  - Updates on the IDLE→SERVE edge.
  - Holds through SERVE and the following IDLE cycle.
- Reset, including mid-transaction, forces these values immediately:
  - state=IDLE, `mem_read`=0, `mem_write`=0
  - `mem_address`=0, `mem_wdata`=0, `mem_wmask`=0
  - `grant_d`=0, last-grant=I
  - `i_resp`=0, `d_resp`=0
- `i_rdata`/`d_rdata` follow `mem_rdata`.

## Timing
- Request latency: a request sampled in IDLE at edge N gives `mem_read`/`mem_write`=1 in cycle N+1.
- Response latency: 0 cycles. `x_resp` is in the same cycle as `mem_resp`.
- Turnaround:
  - `mem_resp` in cycle M → IDLE in M+1 → next memory command earliest in M+2.
  - The memory sees one idle cycle between back-to-back transactions.
- Requesters drop or replace their request on the edge that samples `x_resp`. The IDLE cycle at M+1 therefore sees the updated request.
- `mem_resp` in IDLE is ignored. No `_resp` is generated.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin tie-break.
  - When both request in IDLE, grant the side not granted last.
  - The last-grant register updates on every grant and resets to I, so the first tie after reset goes to D.
- `MEM_ARB_RR_EN` undefined: fixed priority. D always wins ties, and there is no last-grant register.

## Test plan
- Lone I read:
  - Stimulus: `i_read`=1, `i_addr`=0x0000_0060, memory answers 2 cycles later with 0x1234_5678.
  - Required: `mem_read`=1 with address 0x60 one cycle after the request; `i_resp`=1 and `i_rdata`=0x1234_5678 in the same cycle as `mem_resp`; `d_resp`=0 throughout.
- Lone D write:
  - Stimulus: `d_write`=1, addr 0x100, wdata 0xDEAD_BEEF, wmask 0b0011.
  - Required: memory port shows exactly those values; `mem_read`=0; `grant_d`=1; `d_resp` pulses once.
- Simultaneous I read and D read, three times back-to-back:
  - Without `MEM_ARB_RR_EN`: grant order D, D, D; I is served only after D stops requesting.
  - With `MEM_ARB_RR_EN`: grant order D, I, D.
- Input change during service:
  - Stimulus: while SERVE_I, change `i_addr` to 0x200 and raise `d_write`.
  - Required: `mem_address` stays at the original value; D is served only after the I response plus one IDLE cycle.
- Reset during service:
  - Stimulus: assert `rst` between the memory command and `mem_resp`.
  - Required: `mem_read`/`mem_write`, `grant_d` and both `_resp` outputs go to 0 asynchronously; after release, a fresh I request completes normally.
